ex_div: RTL and testbench
=========================

EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted, takes effect immediately, independent of clk).
REQ-003 SHALL have port start_i  input  1  divide request from EX stage; held high until result consumed.
REQ-004 SHALL have port annul_i  input  1  cancel current division (pipeline flush).
REQ-005 SHALL have port signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-006 SHALL have port opdata1_i  input  32  dividend.
REQ-007 SHALL have port opdata2_i  input  32  divisor.
REQ-008 SHALL have port result_o  output  64  [63:32] remainder (HI), [31:0] quotient (LO).
REQ-009 SHALL have port ready_o  output  1  result_o valid.

Function
REQ-010 SHALL implement FSM states FREE, BYZERO, ON, END; reset state FREE.
REQ-011 FREE: start_i=1 and annul_i=0 at edge E0 -> BYZERO if opdata2_i==0, else ON; otherwise stay FREE.
REQ-012 At E0, SHALL capture signed_div_i, operand signs and operand magnitudes (two's-complement negate of negative operands when signed); later input changes are ignored.
REQ-013 ON: restoring shift-subtract, one quotient bit per edge, MSB first, edges E1..E32; 6-bit counter 0..32.
REQ-014 Each step: 33-bit partial remainder minus divisor; if non-negative, keep difference and shift in 1; else keep remainder and shift in 0.
REQ-015 After step 32 (edge E32), state -> END; result correction (sign fix) computed from internal registers.
REQ-016 Signed sign rule: quotient negated if operand signs differ; remainder takes dividend sign; magnitude arithmetic modulo 2^32.
REQ-017 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-018 BYZERO: at next edge -> END with quotient 0, remainder 0.
REQ-019 END: ready_o=1 and result_o valid from the edge after entering END (E33 for ON path, E2 for BYZERO path); held while start_i=1.
REQ-020 END with start_i=0 -> FREE at next edge; ready_o=0, result_o=0 at that edge.
REQ-021 ON or BYZERO with annul_i=1 or start_i=0 -> FREE at next edge, no ready_o pulse, counter cleared.
REQ-022 annul_i=1 in FREE SHALL block acceptance of start_i that cycle.
REQ-023 result_o SHALL be 0 whenever ready_o=0.
REQ-024 A new start accepted in FREE the cycle after returning from END/annul (no dead cycle beyond FREE).
REQ-025 Total latency start-sampled to ready_o high: 33 edges (nonzero divisor), 2 edges (zero divisor).

Reset
REQ-026 rst=0 SHALL asynchronously force state FREE, counter 0, ready_o=0, result_o=0, all datapath registers 0.
REQ-027 Reset mid-division SHALL discard the operation; after release, FSM idles in FREE until a fresh start_i.

Verification
REQ-028 Unsigned 100 / 7, start held -> ready_o rises 33 edges after E0, result_o = {0x00000002, 0x0000000E}.
REQ-029 Signed -7 / 2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; same operands unsigned -> {0x00000001, 0x7FFFFFFC}.
REQ-030 Divisor 0 (dividend 0x12345678) -> ready_o high 2 edges after E0, result_o = 0.
REQ-031 Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-032 annul_i pulsed at E10 -> FREE at E11, ready_o never rises; new start 50 / 5 then completes with {0, 10} after 33 edges.
REQ-033 rst low at E20 mid-division -> ready_o/result_o 0 immediately (before next edge); after release, idle until start_i, then 9 / 4 -> {1, 2}.

Source files
------------

// File: rtl/ex_div.sv
// Multi-cycle 32-bit divider for the EX stage. It uses restoring shift-subtract,
// one quotient bit per clock, and returns {remainder, quotient} with a ready flag.
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [32:0] partial;
  logic [32:0] diff;
  logic [31:0] mag1, mag2;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    // quo_q starts out holding the dividend. Each step shifts its MSB into the
    // remainder and shifts the new quotient bit in at the bottom.
    partial = {rem_q, quo_q[31]};
    diff    = partial - {1'b0, dvsr_q};
    mag1    = (signed_div_i && opdata1_i[31]) ? 32'd0 - opdata1_i : opdata1_i;
    mag2    = (signed_div_i && opdata2_i[31]) ? 32'd0 - opdata2_i : opdata2_i;
    quo_fix = neg_quo_q ? 32'd0 - quo_q : quo_q;
    rem_fix = neg_rem_q ? 32'd0 - rem_q : rem_q;
  end

  // NOTE: every output of this block gets a default first, so no path can leave a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = 1'b0;
    result_d  = 64'd0;

    case (state_q)
      FREE: begin
        if (start_i && !annul_i) begin
          neg_quo_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_d = signed_div_i && opdata1_i[31];
          rem_d     = 32'd0;
          cnt_d     = 6'd0;
          if (opdata2_i == 32'd0) begin
            quo_d   = 32'd0;
            dvsr_d  = 32'd0;
            state_d = BYZERO;
          end else begin
            quo_d   = mag1;
            dvsr_d  = mag2;
            state_d = ON;
          end
        end
      end

      BYZERO: begin
        if (annul_i || !start_i) begin
          cnt_d   = 6'd0;
          state_d = FREE;
        end else begin
          state_d = END;
        end
      end

      ON: begin
        if (annul_i || !start_i) begin
          cnt_d   = 6'd0;
          state_d = FREE;
        end else begin
          // Bit 32 of the wrapped difference is set exactly when partial < divisor.
          if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = partial[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = END;
          end
        end
      end

      END: begin
        if (start_i) begin
          ready_d  = 1'b1;
          result_d = {rem_fix, quo_fix};
        end else begin
          cnt_d   = 6'd0;
          state_d = FREE;
        end
      end

      default: state_d = FREE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every register takes the value from before the edge.
  // NOTE: the datapath registers are reset as well, so nothing left over from an aborted divide is visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FREE;
      cnt_q     <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvsr_q    <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div. The driver queues the expected result and its arrival cycle.
// The monitor checks every ready_o rising edge against that queue.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic [63:0] result_o;
  logic        ready_o;

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cycle   = 0;
  logic        prev_ready = 1'b0;
  logic [63:0] held = 64'd0;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  // Reference: plain integer division in 64 bits, truncating toward zero.
  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
    end else begin
      sa  = longint'({32'd0, a});
      sb_ = longint'({32'd0, b});
    end
    q = sa / sb_;
    r = sa % sb_;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic push_exp(input bit s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res = model(s, a, b);
    e.at  = cycle + 1 + ((b == 32'd0) ? 2 : 33);
    sb.push_back(e);
  endtask

  // Present a request on a negedge, then scramble the operands after E0.
  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input bit push);
    @(negedge clk);
    start_i      = 1'b1;
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    if (push) push_exp(s, a, b);
    @(negedge clk);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
  endtask

  // A hold value below zero returns while ready_o is still high.
  task automatic wait_ready(input int hold);
    for (int i = 0; i < 40 && !ready_o; i++) @(negedge clk);
    check("ready_seen", 64'(ready_o), 64'd1);
    if (hold >= 0) begin
      repeat (hold) @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      check("ready_drop", {result_o[62:0], ready_o}, 64'd0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_ready = 1'b0;
    end else begin
      if (ready_o && !prev_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 64'(ready_o), 64'd0);
        end else begin
          e = sb.pop_front();
          check("result", result_o, e.res);
          check("latency", 64'(cycle), 64'(e.at));
        end
        held = result_o;
      end else if (ready_o) begin
        check("hold", result_o, held);
      end else begin
        check("idle_zero", result_o, 64'd0);
      end
      prev_ready = ready_o;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bit          s;

    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    issue(1'b0, 32'd100, 32'd7, 1'b1);                 wait_ready(2);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);           wait_ready(1);
    issue(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1);           wait_ready(0);
    issue(1'b0, 32'h1234_5678, 32'd0, 1'b1);           wait_ready(1);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);   wait_ready(1);

    // annul_i in FREE blocks acceptance until it drops.
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; signed_div_i = 1'b0;
    opdata1_i = 32'd77; opdata2_i = 32'd3;
    repeat (3) @(negedge clk);
    annul_i = 1'b0;
    push_exp(1'b0, 32'd77, 32'd3);
    wait_ready(0);

    // Mid-division annul, then an immediate new request with start_i still high.
    issue(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd50; opdata2_i = 32'd5;
    push_exp(1'b0, 32'd50, 32'd5);
    @(negedge clk);
    wait_ready(1);

    // Reset mid-division: the divide is discarded and the FSM stays idle.
    issue(1'b0, 32'd12345, 32'd11, 1'b0);
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (5) @(negedge clk);
    issue(1'b0, 32'd9, 32'd4, 1'b1);                   wait_ready(0);

    // Reset while a result is held: the outputs clear before the next edge.
    issue(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);   wait_ready(-1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_end_ready", 64'(ready_o), 64'd0);
    check("rst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 30; n++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = 32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      issue(s, a, b, 1'b1);
      wait_ready(int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
